// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the shared UART transmitter.
// o_dbg_state mirrors the arbiter FSM state (one-hot) for checkers.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   // Handshake: requester k's character transfers on a clock edge where
   // i_req_valid[k] and o_req_ready[k] are both 1. o_req_ready is one-hot-or-zero,
   // may depend combinationally on i_req_valid, and valid must not wait for ready.
   logic [NUM_REQ-1:0]           i_req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] i_req_data;
   logic [NUM_REQ-1:0]           i_req_lock;
   logic [NUM_REQ-1:0]           o_req_ready;
   logic                         o_tx_data_valid;
   logic [DATA_BITS-1:0]         o_tx_data;
   logic                         i_tx_busy;
   logic [ID_W-1:0]              o_grant_id;
   logic                         o_err;
   logic [3:0]                   o_dbg_state;

   modport slave (
      input  i_req_valid, i_req_data, i_req_lock, i_tx_busy,
      output o_req_ready, o_tx_data_valid, o_tx_data, o_grant_id, o_err, o_dbg_state
   );

   modport master (
      output i_req_valid, i_req_data, i_req_lock, i_tx_busy,
      input  o_req_ready, o_tx_data_valid, o_tx_data, o_grant_id, o_err, o_dbg_state
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock that shares one UART transmitter
// between NUM_REQ requesters, with a timeout on the transmitter's busy response.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 15
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_ISSUE     = 4'b0010,
      ST_WAIT_BUSY = 4'b0100,
      ST_WAIT_DONE = 4'b1000
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [ID_W-1:0]      r_rr_ptr;
   logic [ID_W-1:0]      r_lock_id;
   logic [ID_W-1:0]      r_grant_id;
   logic                 r_lock_active;
   logic                 r_err;
   logic [CNT_W-1:0]     r_cnt;
   logic [DATA_BITS-1:0] r_tx_data;

   logic [NUM_REQ-1:0]   w_eligible;
   logic [NUM_REQ-1:0]   w_ready;
   logic [ID_W-1:0]      w_winner;
   logic [ID_W:0]        w_sum;
   logic                 w_found;
   logic                 w_lock_release;
   logic                 w_accept;
   logic                 w_timeout;

   assign w_lock_release = r_lock_active && !bus.i_req_lock[r_lock_id] && !bus.i_req_valid[r_lock_id];

   // Search starts at r_rr_ptr; w_sum carries one extra bit so the wrap is a single subtract.
   always_comb begin
      w_eligible = bus.i_req_valid;
      if (r_lock_active) begin
         w_eligible            = '0;
         w_eligible[r_lock_id] = bus.i_req_valid[r_lock_id];
      end
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         if (!w_found && w_eligible[w_sum[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_accept = (r_state == ST_IDLE) && !rst && !bus.i_tx_busy && !w_lock_release && w_found;

   always_comb begin
      w_ready = '0;
      if (w_accept) w_ready[w_winner] = 1'b1;
   end

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         ST_IDLE:      if (w_accept) w_next = ST_ISSUE;
         ST_ISSUE:     w_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (bus.i_tx_busy) begin
               w_next = ST_WAIT_DONE;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_next    = ST_IDLE;
               w_timeout = 1'b1;
            end
         end
         ST_WAIT_DONE: if (!bus.i_tx_busy) w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_lock_active <= 1'b0;
         r_lock_id     <= '0;
         r_grant_id    <= '0;
         r_tx_data     <= '0;
         r_cnt         <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_timeout;
         if (w_accept) begin
            r_tx_data     <= bus.i_req_data[w_winner*DATA_BITS +: DATA_BITS];
            r_lock_active <= bus.i_req_lock[w_winner];
            r_lock_id     <= w_winner;
            r_grant_id    <= w_winner;
            r_rr_ptr      <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
         end else if (r_state == ST_IDLE && w_lock_release) begin
            r_lock_active <= 1'b0;
         end
         // Counter reaches TIMEOUT on the cycle the FSM leaves WAIT_BUSY without busy.
         if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == ST_WAIT_BUSY && !bus.i_tx_busy) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.o_req_ready     = w_ready;
   assign bus.o_tx_data_valid = (r_state == ST_ISSUE);
   assign bus.o_tx_data       = r_tx_data;
   assign bus.o_grant_id      = r_grant_id;
   assign bus.o_err           = r_err;
   assign bus.o_dbg_state     = r_state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table-driven arbitration rounds plus
// hand-written sequences for rotation, lock, timeout, external busy and reset.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int DATA_BITS = 8;
   localparam int TIMEOUT   = 15;
   localparam int ID_W      = 2;
   localparam logic [3:0] S_IDLE = 4'b0001;
   localparam logic [3:0] S_WB   = 4'b0100;
   localparam logic [3:0] S_WD   = 4'b1000;

   typedef struct {
      logic [NUM_REQ-1:0] valid;
      logic [NUM_REQ-1:0] lock;
      int                 exp_id;
      int                 lat;
   } row_t;

   logic                         clk;
   logic                         rst;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           req_lock;
   logic                         force_busy;
   logic                         model_en;
   logic                         model_busy;
   logic                         strobe_s = 1'b0;
   int                           busy_len;
   int                           errors = 0;
   int                           checks = 0;
   int                           cyc = 0;
   int                           last_strobe = -1;
   int                           exact_gap = 0;
   logic [ID_W+DATA_BITS-1:0]    exp_q[$];
   row_t                         tbl[8];

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.i_req_valid = req_valid;
   assign bus.i_req_data  = req_data;
   assign bus.i_req_lock  = req_lock;
   assign bus.i_tx_busy   = model_en ? model_busy : force_busy;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transmitter model: busy from the cycle after the strobe, busy_len cycles ----------------
   initial begin : tx_model
      int busy_left;
      busy_left  = 0;
      model_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst || !model_en) busy_left = 0;
         else if (strobe_s)    busy_left = busy_len;
         model_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   initial begin : monitor
      logic [ID_W+DATA_BITS-1:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         strobe_s = bus.o_tx_data_valid;
         check("ready_onehot0", 32'($onehot0(bus.o_req_ready)), 1);
         if (bus.o_dbg_state != S_IDLE) check("ready_outside_idle", 32'(bus.o_req_ready), 0);
         if (bus.o_tx_data_valid) begin
            check("strobe_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("grant_id", 32'(bus.o_grant_id), 32'(e[ID_W+DATA_BITS-1:DATA_BITS]));
               check("tx_data", 32'(bus.o_tx_data), 32'(e[DATA_BITS-1:0]));
            end
            if (last_strobe >= 0) begin
               if (exact_gap > 0) check("strobe_gap", 32'(cyc - last_strobe), 32'(exact_gap));
               else               check("strobe_min_gap", 32'((cyc - last_strobe) >= 4), 1);
            end
            last_strobe = cyc;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.o_dbg_state == S_IDLE && !bus.i_tx_busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_idle_reached"}, 32'(ok), 1);
   endtask

   task automatic wait_hs(input string name, output logic [NUM_REQ-1:0] hs, output int lat);
      hs  = '0;
      lat = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.o_req_ready != '0) begin
            hs  = bus.o_req_ready;
            lat = i;
            break;
         end
      end
      check({name, "_hs_seen"}, 32'(lat >= 0), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},    32'(bus.o_req_ready), 0);
      check({tag, "_tx_valid"}, 32'(bus.o_tx_data_valid), 0);
      check({tag, "_tx_data"},  32'(bus.o_tx_data), 0);
      check({tag, "_grant_id"}, 32'(bus.o_grant_id), 0);
      check({tag, "_err"},      32'(bus.o_err), 0);
      check({tag, "_state"},    32'(bus.o_dbg_state), 32'(S_IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [NUM_REQ-1:0] hs;
      int lat, n2, t_wb, t_err, t_hs2, n_err;
      logic done;
      logic [3:0] err_state;

      tbl[0] = '{4'b1010, 4'b0000, 1, 0};
      tbl[1] = '{4'b0011, 4'b0000, 0, 0};
      tbl[2] = '{4'b1111, 4'b0000, 1, 0};
      tbl[3] = '{4'b1000, 4'b1000, 3, 0};
      tbl[4] = '{4'b1001, 4'b1000, 3, 0};
      tbl[5] = '{4'b0001, 4'b0000, 0, 1};
      tbl[6] = '{4'b0110, 4'b0000, 1, 0};
      tbl[7] = '{4'b0100, 4'b0000, 2, 0};

      rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0;
      force_busy = 1'b0; model_en = 1'b0; busy_len = 1;
      #2 req_valid = 4'b1111;
      @(negedge clk);
      check_reset_outputs("por");
      tick();
      rst = 1'b0; req_valid = '0;

      // Rotation with all four held valid.
      tick();
      model_en = 1'b1; busy_len = 20;
      req_data = 32'h1312_1110;
      exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd1, 8'h11});
      exp_q.push_back({2'd2, 8'h12}); exp_q.push_back({2'd3, 8'h13});
      exp_q.push_back({2'd0, 8'h10});
      req_valid = 4'b1111;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("rr_drained", 32'(exp_q.size()), 0);
      tick();
      req_valid = '0;
      wait_idle("rr");

      // Lock: requester 2 keeps the grant over requester 0 for its locked burst.
      tick();
      busy_len = 1; last_strobe = -1; exact_gap = 4;
      req_data = '0; req_data[23:16] = 8'h20; req_data[7:0] = 8'h30;
      req_lock = 4'b0100; req_valid = 4'b0101;
      exp_q.push_back({2'd2, 8'h20}); exp_q.push_back({2'd2, 8'h21});
      exp_q.push_back({2'd2, 8'h22}); exp_q.push_back({2'd2, 8'h23});
      exp_q.push_back({2'd0, 8'h30});
      n2 = 0; done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         hs = bus.o_req_ready & bus.i_req_valid;
         tick();
         if (hs[2]) begin
            n2++;
            req_data[23:16] = 8'(32'h20 + n2);
            req_lock[2]     = (n2 < 3);
            if (n2 == 4) req_valid[2] = 1'b0;
         end
         if (hs[0]) begin
            req_valid[0] = 1'b0;
            done = 1'b1;
         end
      end
      check("lock_done", 32'(done), 1);
      check("lock_req2_count", 32'(n2), 4);
      wait_idle("lock");
      exact_gap = 0;

      // Busy never rises: timeout, then the next requester.
      tick();
      model_en = 1'b0; force_busy = 1'b0;
      req_lock = '0; req_data = '0; req_data[15:8] = 8'h51; req_data[23:16] = 8'h52;
      req_valid = 4'b0110;
      exp_q.push_back({2'd1, 8'h51}); exp_q.push_back({2'd2, 8'h52});
      t_wb = -1; t_err = -1; t_hs2 = -1; n_err = 0; err_state = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.o_dbg_state == S_WB && t_wb < 0) t_wb = i;
         if (bus.o_err) begin
            if (t_err < 0) begin
               t_err = i;
               err_state = bus.o_dbg_state;
            end
            n_err++;
         end
         hs = bus.o_req_ready & bus.i_req_valid;
         if (hs[2] && t_hs2 < 0) t_hs2 = i;
         tick();
         if (hs[1]) req_valid[1] = 1'b0;
         if (hs[2]) req_valid[2] = 1'b0;
      end
      check("to_err_delay", 32'(t_err - t_wb), 15);
      check("to_err_state", 32'(err_state), 32'(S_IDLE));
      check("to_err_pulses", 32'(n_err), 2);
      check("to_next_grant", 32'(t_hs2), 32'(t_err));
      wait_idle("timeout");

      // External busy blocks the grant until it falls.
      tick();
      force_busy = 1'b1;
      req_data = '0; req_data[15:8] = 8'h61; req_valid = 4'b0010;
      exp_q.push_back({2'd1, 8'h61});
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("busy_no_ready", 32'(bus.o_req_ready), 0);
      end
      tick();
      force_busy = 1'b0; model_en = 1'b1; busy_len = 1;
      @(negedge clk);
      check("busy_fall_grant", 32'(bus.o_req_ready), 32'b0010);
      tick();
      req_valid = '0;
      wait_idle("busy");

      // Reset in WAIT_DONE, then requester 0 wins from rr_ptr=0.
      tick();
      busy_len = 20;
      req_data = '0; req_data[15:8] = 8'h71; req_valid = 4'b0010;
      exp_q.push_back({2'd1, 8'h71});
      wait_hs("rst_pre", hs, lat);
      check("rst_pre_ready", 32'(hs), 32'b0010);
      tick();
      req_valid = '0;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.o_dbg_state == S_WD) begin
            done = 1'b1;
            break;
         end
      end
      check("rst_wait_done_seen", 32'(done), 1);
      tick();
      rst = 1'b1;
      req_data[7:0] = 8'h80; req_data[31:24] = 8'h83; req_valid = 4'b1001;
      #1;
      check_reset_outputs("midrst");
      tick();
      tick();
      rst = 1'b0;
      exp_q.push_back({2'd0, 8'h80});
      wait_hs("rst_post", hs, lat);
      check("rst_post_ready", 32'(hs), 32'b0001);
      check("rst_post_latency", 32'(lat), 0);
      tick();
      req_valid = '0;
      wait_idle("rst");

      // Table-driven arbitration rounds; rr_ptr and lock carry between rows.
      busy_len = 1;
      for (int r = 0; r < 8; r++) begin
         wait_idle("row");
         tick();
         req_lock = tbl[r].lock;
         for (int k = 0; k < NUM_REQ; k++) req_data[k*DATA_BITS +: DATA_BITS] = 8'(r*16 + k);
         req_valid = tbl[r].valid;
         exp_q.push_back({2'(tbl[r].exp_id), 8'(r*16 + tbl[r].exp_id)});
         wait_hs("row", hs, lat);
         check($sformatf("row%0d_ready", r), 32'(hs), 32'(1 << tbl[r].exp_id));
         check($sformatf("row%0d_latency", r), 32'(lat), 32'(tbl[r].lat));
         tick();
         req_valid = '0;
      end
      wait_idle("table");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: got still running expected finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit reached");
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the character width, matching the transmitter's DATA_BITS.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles to wait for transmitter busy after issue.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port i_req_valid, input, NUM_REQ, with bit k meaning requester k presents a character.
REQ-007 The block SHALL have port i_req_data, input, NUM_REQ*DATA_BITS, with slice [k*DATA_BITS +: DATA_BITS] being requester k's character.
REQ-008 The block SHALL have port i_req_lock, input, NUM_REQ, with bit k meaning requester k wants to keep the grant after this character.
REQ-009 The block SHALL have port o_req_ready, output, NUM_REQ, a one-hot-or-zero accept strobe.
REQ-010 The block SHALL have port o_tx_data_valid, output, 1, a single-cycle start strobe to the transmitter.
REQ-011 The block SHALL have port o_tx_data, output, DATA_BITS, the character to the transmitter, held stable from issue until return to IDLE.
REQ-012 The block SHALL have port i_tx_busy, input, 1, the transmitter busy flag.
REQ-013 The block SHALL have port o_grant_id, output, clog2(NUM_REQ), the requester that owns the current or last character.
REQ-014 The block SHALL have port o_err, output, 1, a single-cycle pulse when a busy timeout occurs.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE (one-hot encoded).
REQ-016 In IDLE with i_tx_busy=0 and at least one eligible valid, the block SHALL combinationally assert o_req_ready for exactly the winner, capture its data into o_tx_data and its lock bit, set o_grant_id, and go to ISSUE.
REQ-017 A character SHALL be transferred only on a cycle where i_req_valid[k] and o_req_ready[k] are both 1; o_req_ready SHALL be 0 in every state other than IDLE.
REQ-018 Arbitration SHALL be round-robin: the search starts at rr_ptr and wraps modulo NUM_REQ; on each acceptance rr_ptr becomes (winner+1) mod NUM_REQ.
REQ-019 When lock_active=1, only requester lock_id SHALL be eligible; other requesters' valids are ignored.
REQ-020 On acceptance, lock_active SHALL be set to the captured lock bit and lock_id to the winner.
REQ-021 In IDLE, if lock_active=1 and both i_req_lock[lock_id]=0 and i_req_valid[lock_id]=0, lock_active SHALL clear that cycle, with arbitration resuming the next cycle.
REQ-022 In IDLE with i_tx_busy=1, no grant SHALL be issued.
REQ-023 In ISSUE, o_tx_data_valid SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_BUSY, and the timeout counter SHALL be cleared.
REQ-024 In WAIT_BUSY, i_tx_busy=1 SHALL move the FSM to WAIT_DONE; otherwise the counter SHALL increment, and when it reaches TIMEOUT the FSM SHALL return to IDLE with o_err=1 for one cycle.
REQ-025 In WAIT_DONE, i_tx_busy=0 SHALL return the FSM to IDLE; no timeout applies.
REQ-026 Minimum spacing between successive o_tx_data_valid pulses SHALL be 4 cycles (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
REQ-027 Simultaneous valids SHALL be resolved solely by rr_ptr; a requester deasserting valid before acceptance SHALL lose nothing.

Reset
REQ-028 On rst=1, the state SHALL become IDLE, with o_req_ready=0, o_tx_data_valid=0, o_tx_data=0, o_grant_id=0, o_err=0, rr_ptr=0, lock_active=0 and the counter at 0.
REQ-029 Reset mid-transfer SHALL abandon the in-flight character; the first grant after reset release SHALL follow REQ-016 from rr_ptr=0.

Verification
REQ-030 The bench SHALL drive valid on requesters 0..3 all held with data 0x10..0x13 and a transmitter model (busy 1 cycle after strobe, 20 cycles long) -> issue order 0,1,2,3,0, o_grant_id matching each issue.
REQ-031 The bench SHALL drive requester 2 valid with lock=1 for 3 characters then lock=0, while requester 0 is valid throughout -> three req-2 characters back to back, then req-2's last character, then requester 0.
REQ-032 The bench SHALL hold i_tx_busy=0 permanently after issue -> o_err pulses exactly 15 cycles after WAIT_BUSY entry, the FSM returns to IDLE, and the next requester is granted.
REQ-033 The bench SHALL hold i_tx_busy=1 externally while requester 1 is valid -> o_req_ready stays 0, and the grant occurs the cycle busy falls.
REQ-034 The bench SHALL assert rst during WAIT_DONE -> all outputs reach their reset values immediately, and requester 0 wins first after release when 0 and 3 are valid.
